fetch_stage: RTL and testbench

- Instruction-fetch stage of the 3-stage RV32I core; sits directly upstream of instruction pre-decode.
- Owns the PC register and drives a synchronous-read instruction memory (1-cycle read latency).
- Presents one instruction per cycle on `instr`/`opcode`/`pc` with a valid flag.
- Handles stall (hold) and redirect (branch/jump kill) from later stages.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the fetch stage's pipeline-control, IMEM and
// pre-decode signals into one bundle.
//   master (fetch stage): drives imem_addr, instr, opcode, pc, instr_valid;
//                         receives stall, redirect_valid, redirect_target, imem_dout.
//   slave  (pipeline/IMEM side): the reverse directions.
interface fetch_stage_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 14
);
  logic               stall;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_target;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_dout;
  logic [XLEN-1:0]    instr;
  logic [6:0]         opcode;
  logic [XLEN-1:0]    pc;
  logic               instr_valid;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_dout,
    output imem_addr, instr, opcode, pc, instr_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_dout,
    input  imem_addr, instr, opcode, pc, instr_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 3-stage RV32I core.
// Owns the PC, drives a synchronous-read IMEM (1-cycle latency) and presents
// one instruction per cycle to pre-decode, honouring stall and redirect.
// Ports:
//   clk    core clock, rising-edge
//   rst_n  synchronous active-low reset
//   bus    fetch_stage_if.master: stall, redirect_valid, redirect_target,
//          imem_addr, imem_dout, instr, opcode, pc, instr_valid
//
// state | meaning
// BOOT  | first cycle after reset; RESET_PC read issued, bubble output
// RUN   | instr comes straight from IMEM read data
// HOLD  | stalled; instr replayed from hold_instr, IMEM data ignored
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h4000_0000,
  parameter int              IMEM_AW   = 14,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] hold_instr, hold_nx;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic            valid_o;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;

  assign redir_pc = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign pc_inc   = fetch_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nx;
      fetch_pc   <= pc_next;
      hold_instr <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_next  = pc_inc;
    hold_nx  = hold_instr;
    instr_o  = NOP_INSTR;
    pc_o     = fetch_pc;
    valid_o  = 1'b0;

    case (state)
      BOOT: begin
        // stall/redirect deliberately ignored: nothing valid is in flight yet
        pc_next  = fetch_pc;
        pc_o     = RESET_PC;
        state_nx = RUN;
      end

      RUN: begin
        instr_o = bus.imem_dout;
        valid_o = 1'b1;
        if (bus.redirect_valid) begin
          // wrong-path kill in the same cycle
          instr_o  = NOP_INSTR;
          valid_o  = 1'b0;
          pc_next  = redir_pc;
          state_nx = RUN;
        end else if (bus.stall) begin
          // IMEM data for this PC is only available now; capture it since the
          // re-read issued while stalled is not relied upon
          pc_next  = fetch_pc;
          hold_nx  = bus.imem_dout;
          state_nx = HOLD;
        end
      end

      HOLD: begin
        instr_o = hold_instr;
        valid_o = 1'b1;
        if (bus.redirect_valid) begin
          instr_o  = NOP_INSTR;
          valid_o  = 1'b0;
          pc_next  = redir_pc;
          state_nx = RUN;
        end else if (bus.stall) begin
          pc_next = fetch_pc;
        end else begin
          state_nx = RUN;
        end
      end

      default: begin
        pc_next  = fetch_pc;
        state_nx = BOOT;
      end
    endcase

    // keep IMEM pointed at the boot vector for the whole reset interval
    if (!rst_n) begin
      pc_next = RESET_PC;
    end
  end

  assign bus.imem_addr   = pc_next[IMEM_AW+1:2];
  assign bus.instr       = instr_o;
  assign bus.opcode      = instr_o[6:0];
  assign bus.pc          = pc_o;
  assign bus.instr_valid = valid_o;

  logic unused_bits;
  assign unused_bits = ^{bus.redirect_target[1:0], pc_next[XLEN-1:IMEM_AW+2],
                         pc_next[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] R1  = 32'h4000_0000;
  localparam logic [31:0] R2  = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32), .IMEM_AW(14)) bus1 ();
  fetch_stage_if #(.XLEN(32), .IMEM_AW(14)) bus2 ();

  fetch_stage #(.XLEN(32), .RESET_PC(R1), .IMEM_AW(14), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(R2), .IMEM_AW(14), .NOP_INSTR(NOP)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  logic [31:0] mem [0:16383];

  always @(posedge clk) begin
    bus1.imem_dout <= mem[bus1.imem_addr];
    bus2.imem_dout <= mem[bus2.imem_addr];
  end

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [13:0] addr;
    string       tag;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s.%s actual=%h required=%h", tag, field, act, req);
    end
  endtask

  // monitor: compares whatever the DUTs present against queued expectations
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] op;
    if (q1.size() > 0) begin
      e  = q1.pop_front();
      op = {25'd0, e.instr[6:0]};
      chk(e.tag, "valid",  {31'd0, bus1.instr_valid}, {31'd0, e.v});
      chk(e.tag, "instr",  bus1.instr, e.instr);
      chk(e.tag, "opcode", {25'd0, bus1.opcode}, op);
      chk(e.tag, "pc",     bus1.pc, e.pc);
      chk(e.tag, "addr",   {18'd0, bus1.imem_addr}, {18'd0, e.addr});
    end
    if (q2.size() > 0) begin
      e  = q2.pop_front();
      op = {25'd0, e.instr[6:0]};
      chk(e.tag, "valid",  {31'd0, bus2.instr_valid}, {31'd0, e.v});
      chk(e.tag, "instr",  bus2.instr, e.instr);
      chk(e.tag, "opcode", {25'd0, bus2.opcode}, op);
      chk(e.tag, "pc",     bus2.pc, e.pc);
      chk(e.tag, "addr",   {18'd0, bus2.imem_addr}, {18'd0, e.addr});
    end
  end

  task automatic push2(input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [13:0] addr,
                       input string tag);
    exp_t e;
    e.v = v; e.instr = instr; e.pc = pc; e.addr = addr; e.tag = tag;
    q2.push_back(e);
  endtask

  // one cycle: drive inputs, queue expected dut outputs, advance past the edge
  task automatic step(input logic st, input logic rv, input logic [31:0] tgt,
                      input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [13:0] addr,
                      input string tag);
    exp_t e;
    bus1.stall           = st;
    bus1.redirect_valid  = rv;
    bus1.redirect_target = tgt;
    e.v = v; e.instr = instr; e.pc = pc; e.addr = addr; e.tag = tag;
    q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'(i) + 32'h100;
    bus2.stall           = 1'b0;
    bus2.redirect_valid  = 1'b0;
    bus2.redirect_target = 32'd0;
    bus1.stall           = 1'b0;
    bus1.redirect_valid  = 1'b0;
    bus1.redirect_target = 32'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // reset state and free run
    step(0, 0, 0,            0, NOP,          R1,               14'd0,  "reset");
    rst_n = 1'b1;
    step(0, 0, 0,            0, NOP,          R1,               14'd0,  "boot");
    step(0, 0, 0,            1, 32'h100,      R1,               14'd1,  "run0");
    step(0, 0, 0,            1, 32'h101,      32'h4000_0004,    14'd2,  "run1");
    step(0, 0, 0,            1, 32'h102,      32'h4000_0008,    14'd3,  "run2");
    step(0, 0, 0,            1, 32'h103,      32'h4000_000C,    14'd4,  "run3");
    // back to 0x08, then stall there 3 cycles while IMEM[2] changes
    step(0, 1, 32'h4000_0008, 0, NOP,         32'h4000_0010,    14'd2,  "redir08");
    mem[2] = 32'hDEAD_0002;
    step(1, 0, 0,            1, 32'h102,      32'h4000_0008,    14'd2,  "stall0");
    step(1, 0, 0,            1, 32'h102,      32'h4000_0008,    14'd2,  "stall1");
    step(1, 0, 0,            1, 32'h102,      32'h4000_0008,    14'd2,  "stall2");
    step(0, 0, 0,            1, 32'h102,      32'h4000_0008,    14'd3,  "release");
    mem[2] = 32'h102;
    step(0, 0, 0,            1, 32'h103,      32'h4000_000C,    14'd4,  "after_stall");
    // misaligned redirect target from pc 0x04
    step(0, 1, 32'h4000_0004, 0, NOP,         32'h4000_0010,    14'd1,  "redir04");
    step(0, 1, 32'h4000_0103, 0, NOP,         32'h4000_0004,    14'd64, "kill");
    step(0, 0, 0,            1, 32'h140,      32'h4000_0100,    14'd65, "target");
    // redirect together with stall while in HOLD
    step(1, 0, 0,            1, 32'h141,      32'h4000_0104,    14'd65, "enter_hold");
    step(1, 1, 32'h4000_0020, 0, NOP,         32'h4000_0104,    14'd8,  "hold_redir");
    step(0, 0, 0,            1, 32'h108,      32'h4000_0020,    14'd9,  "redir_tgt");
    step(0, 0, 0,            1, 32'h109,      32'h4000_0024,    14'd10, "in_run");
    // reset while in HOLD
    step(1, 0, 0,            1, 32'h10A,      32'h4000_0028,    14'd10, "hold_again");
    rst_n = 1'b0;
    step(1, 0, 0,            1, 32'h10A,      32'h4000_0028,    14'd0,  "rst_in_hold");
    push2(0, NOP,        R2,         14'h3FFF, "wrap_reset");
    step(1, 0, 0,            0, NOP,          R1,               14'd0,  "rst_boot");
    rst_n = 1'b1;
    push2(0, NOP,        R2,         14'h3FFF, "wrap_boot");
    step(1, 1, 32'h4000_0020, 0, NOP,         R1,               14'd0,  "boot_ignore");
    push2(1, 32'h40FF,   R2,         14'd0,    "wrap_first");
    step(0, 0, 0,            1, 32'h100,      R1,               14'd1,  "reboot0");
    push2(1, 32'h100,    32'h0,      14'd1,    "wrap_zero");
    step(0, 0, 0,            1, 32'h101,      32'h4000_0004,    14'd2,  "reboot1");
    push2(1, 32'h101,    32'h4,      14'd2,    "wrap_four");
    step(0, 0, 0,            1, 32'h102,      32'h4000_0008,    14'd3,  "reboot2");

    for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
    if (q1.size() > 0 || q2.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain actual=%0d pending required=0", q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
